// File: rtl/pe_array_pkg.sv
// rtl/pe_array_pkg.sv - shared PE-array geometry, ID widths and collector state type
package pe_array_pkg;
    localparam int NUMS_PE_ROW = 6;
    localparam int NUMS_PE_COL = 8;
    localparam int NUMS_PE     = NUMS_PE_ROW * NUMS_PE_COL;
    localparam int XID_BITS    = 5;
    localparam int YID_BITS    = 3;
    localparam int DATA_BITS   = 32;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } collector_state_e;
endpackage

// File: rtl/id_match_arbiter.sv
// rtl/id_match_arbiter.sv - tag match against ID tables, lowest-index one-hot grant
module id_match_arbiter #(
    parameter int NUM_ROW = 6,
    parameter int NUM_COL = 8,
    parameter int XID_W   = 5,
    parameter int YID_W   = 3,
    parameter int NUM_PE  = NUM_ROW * NUM_COL
) (
    input  logic [NUM_PE-1:0][XID_W-1:0]  xid_tbl_i,
    input  logic [NUM_ROW-1:0][YID_W-1:0] yid_tbl_i,
    input  logic [XID_W-1:0]              tag_x_i,
    input  logic [YID_W-1:0]              tag_y_i,
    input  logic [NUM_PE-1:0]             pe_en_i,
    input  logic [NUM_PE-1:0]             pe_valid_i,
    output logic [NUM_PE-1:0]             grant_o,
    output logic                          any_o,
    output logic                          multi_o
);
    logic [NUM_PE-1:0] match;
    logic [NUM_PE-1:0] cand;

    for (genvar k = 0; k < NUM_PE; k++) begin : g_match
        assign match[k] = pe_en_i[k] && (xid_tbl_i[k] == tag_x_i)
                       && (yid_tbl_i[k / NUM_COL] == tag_y_i);
    end

    assign cand = match & pe_valid_i;

    // Two's-complement isolates the lowest set bit; clearing it exposes a second candidate.
    assign grant_o = cand & (~cand + NUM_PE'(1));
    assign any_o   = |cand;
    assign multi_o = |(cand & (cand - NUM_PE'(1)));
endmodule

// File: rtl/gon_opsum_collector.sv
// rtl/gon_opsum_collector.sv - GON opsum collector: ID scan tables, PE selection, one-entry output buffer
module gon_opsum_collector #(
    parameter int NUMS_PE_ROW = pe_array_pkg::NUMS_PE_ROW,
    parameter int NUMS_PE_COL = pe_array_pkg::NUMS_PE_COL,
    parameter int XID_BITS    = pe_array_pkg::XID_BITS,
    parameter int YID_BITS    = pe_array_pkg::YID_BITS,
    parameter int DATA_SIZE   = pe_array_pkg::DATA_BITS
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  logic                                      set_xid_i,
    input  logic [XID_BITS-1:0]                       opsum_xid_scan_in_i,
    input  logic                                      set_yid_i,
    input  logic [YID_BITS-1:0]                       opsum_yid_scan_in_i,
    input  logic [XID_BITS-1:0]                       opsum_tag_x_i,
    input  logic [YID_BITS-1:0]                       opsum_tag_y_i,
    input  logic [NUMS_PE_ROW*NUMS_PE_COL-1:0]           pe_en_i,
    input  logic [NUMS_PE_ROW*NUMS_PE_COL-1:0]           pe_opsum_valid_i,
    output logic [NUMS_PE_ROW*NUMS_PE_COL-1:0]           pe_opsum_ready_o,
    input  logic [NUMS_PE_ROW*NUMS_PE_COL*DATA_SIZE-1:0] pe_opsum_data_i,
    output logic                                      glb_opsum_valid_o,
    input  logic                                      glb_opsum_ready_i,
    output logic [DATA_SIZE-1:0]                      pe_data_out_o,
    output logic                                      multi_match_err_o
);
    import pe_array_pkg::*;

    localparam int NUM_PE = NUMS_PE_ROW * NUMS_PE_COL;
    localparam int XPTR_W = $clog2(NUM_PE);
    localparam int YPTR_W = $clog2(NUMS_PE_ROW);

    logic [NUM_PE-1:0][XID_BITS-1:0]      xid_q;
    logic [NUMS_PE_ROW-1:0][YID_BITS-1:0] yid_q;
    logic [XPTR_W-1:0]                    xptr_q, xptr_d;
    logic [YPTR_W-1:0]                    yptr_q, yptr_d;
    collector_state_e                     state_q, state_d;
    logic [DATA_SIZE-1:0]                 data_q, data_d;
    logic                                 err_q, err_d;

    logic [NUM_PE-1:0]    grant;
    logic                 any_grant;
    logic                 multi;
    logic                 accept;
    logic [DATA_SIZE-1:0] sel_data;

    id_match_arbiter #(
        .NUM_ROW (NUMS_PE_ROW),
        .NUM_COL (NUMS_PE_COL),
        .XID_W   (XID_BITS),
        .YID_W   (YID_BITS)
    ) u_arb (
        .xid_tbl_i  (xid_q),
        .yid_tbl_i  (yid_q),
        .tag_x_i    (opsum_tag_x_i),
        .tag_y_i    (opsum_tag_y_i),
        .pe_en_i    (pe_en_i),
        .pe_valid_i (pe_opsum_valid_i),
        .grant_o    (grant),
        .any_o      (any_grant),
        .multi_o    (multi)
    );

    always_comb begin
        xptr_d = '0;
        yptr_d = '0;
        if (set_xid_i)
            xptr_d = (xptr_q == XPTR_W'(NUM_PE - 1)) ? '0 : xptr_q + XPTR_W'(1);
        if (set_yid_i)
            yptr_d = (yptr_q == YPTR_W'(NUMS_PE_ROW - 1)) ? '0 : yptr_q + YPTR_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            xid_q  <= '0;
            yid_q  <= '0;
            xptr_q <= '0;
            yptr_q <= '0;
        end else begin
            xptr_q <= xptr_d;
            yptr_q <= yptr_d;
            if (set_xid_i) xid_q[xptr_q] <= opsum_xid_scan_in_i;
            if (set_yid_i) yid_q[yptr_q] <= opsum_yid_scan_in_i;
        end
    end

    // Accept only from EMPTY: the controller retargets tags on the drain edge.
    assign accept = (state_q == ST_EMPTY) && !set_xid_i && !set_yid_i && any_grant;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_EMPTY;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_FULL;
            ST_FULL:  if (glb_opsum_ready_i) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        pe_opsum_ready_o = '0;
        if (rst_ni && accept) pe_opsum_ready_o = grant;
    end

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NUM_PE; k++)
            if (grant[k]) sel_data = sel_data | pe_opsum_data_i[k*DATA_SIZE +: DATA_SIZE];
    end

    always_comb begin
        data_d = accept ? sel_data : data_q;
        err_d  = err_q | (accept & multi);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            err_q  <= err_d;
        end
    end

    assign glb_opsum_valid_o = (state_q == ST_FULL);
    assign pe_data_out_o     = data_q;
    assign multi_match_err_o = err_q;
endmodule

// File: tb/tb_gon_opsum_collector.sv
// tb/tb_gon_opsum_collector.sv - randomized self-checking bench for gon_opsum_collector
module tb_gon_opsum_collector;
    localparam int ROWS = 6;
    localparam int COLS = 8;
    localparam int NPE  = ROWS * COLS;
    localparam int XW   = 5;
    localparam int YW   = 3;
    localparam int DW   = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              set_x = 1'b0, set_y = 1'b0;
    logic [XW-1:0]     xscan = '0, tag_x = '0;
    logic [YW-1:0]     yscan = '0, tag_y = '0;
    logic [NPE-1:0]    pe_en = '0, pe_valid = '0, pe_ready;
    logic [NPE*DW-1:0] pe_data = '0;
    logic              glb_valid, glb_ready = 1'b0, err;
    logic [DW-1:0]     data_out;

    int tests = 0;
    int fails = 0;

    logic [XW-1:0] xid_m [NPE];
    logic [YW-1:0] yid_m [ROWS];
    bit            err_m = 1'b0;
    logic [DW-1:0] held;
    int            exp_idx, exp_cnt;

    always #5 clk = ~clk;

    gon_opsum_collector dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .set_xid_i           (set_x),
        .opsum_xid_scan_in_i (xscan),
        .set_yid_i           (set_y),
        .opsum_yid_scan_in_i (yscan),
        .opsum_tag_x_i       (tag_x),
        .opsum_tag_y_i       (tag_y),
        .pe_en_i             (pe_en),
        .pe_opsum_valid_i    (pe_valid),
        .pe_opsum_ready_o    (pe_ready),
        .pe_opsum_data_i     (pe_data),
        .glb_opsum_valid_o   (glb_valid),
        .glb_opsum_ready_i   (glb_ready),
        .pe_data_out_o       (data_out),
        .multi_match_err_o   (err)
    );

    // Reference: walk PEs in index order, first eligible one wins, count all eligible.
    function automatic void pick(output int idx, output int cnt);
        idx = -1;
        cnt = 0;
        for (int k = 0; k < NPE; k++) begin
            if (pe_en[k] && pe_valid[k] && xid_m[k] == tag_x && yid_m[k / COLS] == tag_y) begin
                if (idx < 0) idx = k;
                cnt++;
            end
        end
    endfunction

    function automatic logic [NPE-1:0] onehot(input int idx);
        logic [NPE-1:0] v = '0;
        if (idx >= 0) v[idx] = 1'b1;
        return v;
    endfunction

    task automatic rand_data();
        for (int k = 0; k < NPE; k++) pe_data[k*DW +: DW] = $urandom();
    endtask

    task automatic clear_model();
        for (int k = 0; k < NPE; k++) xid_m[k] = '0;
        for (int r = 0; r < ROWS; r++) yid_m[r] = '0;
    endtask

    task automatic scan_x(input int mode);
        for (int k = 0; k < NPE; k++) begin
            xscan = (mode == 0) ? XW'(k % COLS) : (mode == 1) ? '0 : XW'($urandom_range(0, 3));
            xid_m[k] = xscan;
            set_x = 1'b1;
            @(posedge clk); #1;
        end
        set_x = 1'b0;
        xscan = '0;
    endtask

    task automatic scan_y(input int mode);
        for (int r = 0; r < ROWS; r++) begin
            yscan = (mode == 0) ? YW'(r) : (mode == 1) ? '0 : YW'($urandom_range(0, 1));
            yid_m[r] = yscan;
            set_y = 1'b1;
            @(posedge clk); #1;
        end
        set_y = 1'b0;
        yscan = '0;
    endtask

    task automatic test_reset();
        clear_model();
        pe_en = '1;
        pe_valid = '1;
        rand_data();
        #1;
        tests++; if (pe_ready !== '0) begin fails++; $display("FAIL reset_ready act=%h exp=0", pe_ready); end
        tests++; if (glb_valid !== 1'b0) begin fails++; $display("FAIL reset_valid act=%b exp=0", glb_valid); end
        tests++; if (data_out !== '0) begin fails++; $display("FAIL reset_data act=%h exp=0", data_out); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err act=%b exp=0", err); end
        repeat (2) @(posedge clk);
        #1;
        tests++; if (glb_valid !== 1'b0) begin fails++; $display("FAIL reset_hold_valid act=%b exp=0", glb_valid); end
        pe_valid = '0;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_scan_match();
        scan_x(0);
        scan_y(0);
        rand_data();
        pe_en = '1;
        pe_valid = '1;
        tag_x = 5'd3;
        tag_y = 3'd2;
        #1;
        pick(exp_idx, exp_cnt);
        tests++; if (exp_idx != 19) begin fails++; $display("FAIL scan_model_idx act=%0d exp=19", exp_idx); end
        tests++; if (pe_ready !== onehot(exp_idx)) begin fails++; $display("FAIL scan_ready act=%h exp=%h", pe_ready, onehot(exp_idx)); end
        held = pe_data[exp_idx*DW +: DW];
        @(posedge clk); #1;
        tests++; if (glb_valid !== 1'b1) begin fails++; $display("FAIL scan_valid act=%b exp=1", glb_valid); end
        tests++; if (data_out !== held) begin fails++; $display("FAIL scan_data act=%h exp=%h", data_out, held); end
        tests++; if (pe_ready !== '0) begin fails++; $display("FAIL scan_full_ready act=%h exp=0", pe_ready); end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 10; i++) begin
            tag_x = XW'($urandom_range(0, 7));
            tag_y = YW'($urandom_range(0, 5));
            rand_data();
            #1;
            tests++; if (pe_ready !== '0) begin fails++; $display("FAIL bp_ready cyc=%0d act=%h exp=0", i, pe_ready); end
            tests++; if (glb_valid !== 1'b1) begin fails++; $display("FAIL bp_valid cyc=%0d act=%b exp=1", i, glb_valid); end
            tests++; if (data_out !== held) begin fails++; $display("FAIL bp_data cyc=%0d act=%h exp=%h", i, data_out, held); end
            @(posedge clk); #1;
        end
        glb_ready = 1'b1;
        pe_valid = '0;
        #1;
        tests++; if (glb_valid !== 1'b1) begin fails++; $display("FAIL bp_pre_hs_valid act=%b exp=1", glb_valid); end
        @(posedge clk); #1;
        glb_ready = 1'b0;
        tests++; if (glb_valid !== 1'b0) begin fails++; $display("FAIL bp_drain_valid act=%b exp=0", glb_valid); end
        @(posedge clk); #1;
        tests++; if (glb_valid !== 1'b0) begin fails++; $display("FAIL bp_idle_valid act=%b exp=0", glb_valid); end
    endtask

    task automatic test_multi_match();
        scan_x(1);
        scan_y(1);
        rand_data();
        tag_x = '0;
        tag_y = '0;
        pe_en = '1;
        pe_valid = onehot(5) | onehot(12);
        #1;
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL multi_err_before act=%b exp=0", err); end
        pick(exp_idx, exp_cnt);
        if (exp_cnt > 1) err_m = 1'b1;
        tests++; if (pe_ready !== onehot(exp_idx)) begin fails++; $display("FAIL multi_ready act=%h exp=%h", pe_ready, onehot(exp_idx)); end
        held = pe_data[exp_idx*DW +: DW];
        @(posedge clk); #1;
        tests++; if (data_out !== held) begin fails++; $display("FAIL multi_data act=%h exp=%h", data_out, held); end
        tests++; if (err !== err_m) begin fails++; $display("FAIL multi_err act=%b exp=%b", err, err_m); end
        glb_ready = 1'b1;
        pe_valid = '0;
        @(posedge clk); #1;
        glb_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            tests++; if (err !== 1'b1) begin fails++; $display("FAIL multi_err_sticky cyc=%0d act=%b exp=1", i, err); end
        end
    endtask

    task automatic test_gating();
        tag_x = '0;
        tag_y = '0;
        pe_en = '1;
        pe_en[7] = 1'b0;
        pe_valid = onehot(7);
        #1;
        pick(exp_idx, exp_cnt);
        tests++; if (pe_ready !== onehot(exp_idx)) begin fails++; $display("FAIL gate_en_ready act=%h exp=%h", pe_ready, onehot(exp_idx)); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            tests++; if (glb_valid !== 1'b0) begin fails++; $display("FAIL gate_en_valid cyc=%0d act=%b exp=0", i, glb_valid); end
        end
        pe_en = '1;
        set_x = 1'b1;
        xscan = '0;
        #1;
        tests++; if (pe_ready !== '0) begin fails++; $display("FAIL gate_scan_ready act=%h exp=0", pe_ready); end
        @(posedge clk); #1;
        set_x = 1'b0;
        tests++; if (glb_valid !== 1'b0) begin fails++; $display("FAIL gate_scan_valid act=%b exp=0", glb_valid); end
        #1;
        pick(exp_idx, exp_cnt);
        tests++; if (pe_ready !== onehot(exp_idx)) begin fails++; $display("FAIL gate_release_ready act=%h exp=%h", pe_ready, onehot(exp_idx)); end
        pe_valid = '0;
        @(posedge clk); #1;
        tests++; if (glb_valid !== 1'b0) begin fails++; $display("FAIL gate_withdraw_valid act=%b exp=0", glb_valid); end
    endtask

    task automatic setup_word();
        int          k;
        logic [63:0] r;
        k = $urandom_range(0, NPE - 1);
        tag_x = xid_m[k];
        tag_y = yid_m[k / COLS];
        r = {$urandom(), $urandom()};
        pe_valid = r[NPE-1:0];
        pe_valid[k] = 1'b1;
        rand_data();
        pick(exp_idx, exp_cnt);
    endtask

    task automatic test_stream();
        int hold;
        scan_x(2);
        scan_y(2);
        pe_en = '1;
        setup_word();
        for (int w = 0; w < 8; w++) begin
            #1;
            tests++; if (pe_ready !== onehot(exp_idx)) begin fails++; $display("FAIL stream_ready w=%0d act=%h exp=%h", w, pe_ready, onehot(exp_idx)); end
            held = pe_data[exp_idx*DW +: DW];
            if (exp_cnt > 1) err_m = 1'b1;
            @(posedge clk); #1;
            tests++; if (glb_valid !== 1'b1) begin fails++; $display("FAIL stream_valid w=%0d act=%b exp=1", w, glb_valid); end
            tests++; if (data_out !== held) begin fails++; $display("FAIL stream_data w=%0d act=%h exp=%h", w, data_out, held); end
            tests++; if (err !== err_m) begin fails++; $display("FAIL stream_err w=%0d act=%b exp=%b", w, err, err_m); end
            hold = $urandom_range(0, 2);
            for (int h = 0; h < hold; h++) begin
                tests++; if (pe_ready !== '0) begin fails++; $display("FAIL stream_hold_ready w=%0d act=%h exp=0", w, pe_ready); end
                @(posedge clk); #1;
            end
            glb_ready = 1'b1;
            if (w < 7) setup_word();
            else pe_valid = '0;
            #1;
            tests++; if (pe_ready !== '0) begin fails++; $display("FAIL stream_no_passthru w=%0d act=%h exp=0", w, pe_ready); end
            tests++; if (data_out !== held) begin fails++; $display("FAIL stream_hs_data w=%0d act=%h exp=%h", w, data_out, held); end
            @(posedge clk); #1;
            glb_ready = 1'b0;
            tests++; if (glb_valid !== 1'b0) begin fails++; $display("FAIL stream_drain w=%0d act=%b exp=0", w, glb_valid); end
        end
    endtask

    task automatic test_reset_in_full();
        setup_word();
        #1;
        @(posedge clk); #1;
        tests++; if (glb_valid !== 1'b1) begin fails++; $display("FAIL rst_full_pre act=%b exp=1", glb_valid); end
        rst_n = 1'b0;
        clear_model();
        err_m = 1'b0;
        #1;
        tests++; if (glb_valid !== 1'b0) begin fails++; $display("FAIL rst_full_valid act=%b exp=0", glb_valid); end
        tests++; if (data_out !== '0) begin fails++; $display("FAIL rst_full_data act=%h exp=0", data_out); end
        tests++; if (err !== err_m) begin fails++; $display("FAIL rst_full_err act=%b exp=%b", err, err_m); end
        tests++; if (pe_ready !== '0) begin fails++; $display("FAIL rst_full_ready act=%h exp=0", pe_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tag_x = '0;
        tag_y = '0;
        pe_en = '1;
        pe_valid = '1;
        rand_data();
        #1;
        pick(exp_idx, exp_cnt);
        tests++; if (pe_ready !== onehot(exp_idx)) begin fails++; $display("FAIL rst_after_ready act=%h exp=%h", pe_ready, onehot(exp_idx)); end
        held = pe_data[exp_idx*DW +: DW];
        @(posedge clk); #1;
        tests++; if (data_out !== held) begin fails++; $display("FAIL rst_after_data act=%h exp=%h", data_out, held); end
        pe_valid = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_scan_match();
        test_backpressure();
        test_multi_match();
        test_gating();
        test_stream();
        test_reset_in_full();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/gon_opsum_collector.md
Name: gon_opsum_collector

Overview:
- Transmitting end of the GON opsum handshake: owns GLB_opsum_valid and PE_data_out; the pass controller drives GLB_opsum_ready and the opsum tags.
- Holds each PE's opsum XID and each row's opsum YID, loaded through the controller's scan chains.
- Selects the single PE whose IDs match (opsum_tag_X, opsum_tag_Y) and pulls one opsum from it.
- Buffers that opsum in a one-entry output register and presents it to the controller.

Parameters:
- NUMS_PE_ROW, 6, PE array rows.
- NUMS_PE_COL, 8, PE array columns.
- XID_BITS, 5, X ID / tag width.
- YID_BITS, 3, Y ID / tag width.
- DATA_SIZE, 32, opsum word width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- set_XID  in  1  X scan enable.
- opsum_XID_scan_in  in  XID_BITS  X ID for the current scan slot.
- set_YID  in  1  Y scan enable.
- opsum_YID_scan_in  in  YID_BITS  Y ID for the current scan slot.
- opsum_tag_X  in  XID_BITS  target X tag.
- opsum_tag_Y  in  YID_BITS  target Y tag.
- PE_en  in  ROW*COL  per-PE enable.
- PE_opsum_valid  in  ROW*COL  per-PE opsum available.
- PE_opsum_ready  out  ROW*COL  per-PE accept (one-hot or zero).
- PE_opsum_data  in  ROW*COL*DATA_SIZE  packed opsums, PE k at bits [k*DATA_SIZE +: DATA_SIZE].
- GLB_opsum_valid  out  1  buffered opsum valid.
- GLB_opsum_ready  in  1  controller accept.
- PE_data_out  out  DATA_SIZE  buffered opsum.
- multi_match_err  out  1  sticky: more than one PE matched the tag.

Behaviour:
- Reset (rst=0, asynchronous):
  - All XID/YID entries and both scan pointers clear to 0.
  - State returns to EMPTY.
  - GLB_opsum_valid=0, PE_data_out=0, multi_match_err=0.
  - PE_opsum_ready=0 combinationally while reset is asserted.
  - A word held in the buffer when reset asserts is discarded.
- X scan:
  - Each cycle set_XID=1: XID[xptr] <= opsum_XID_scan_in.
  - xptr then increments, wrapping from ROW*COL-1 to 0.
  - When set_XID=0, xptr <= 0.
- Y scan:
  - Each cycle set_YID=1: YID[yptr] <= opsum_YID_scan_in; yptr wraps at ROW-1.
  - When set_YID=0, yptr <= 0.
- Scan-chain mapping: PE k sits at row k/COL, column k%COL; the entry for PE k is loaded on scan cycle k.
- Match rule: match[k] = PE_en[k] & (XID[k]==opsum_tag_X) & (YID[k/COL]==opsum_tag_Y).
- Candidate set: cand = match & PE_opsum_valid.
- FSM has two states, EMPTY and FULL.
- EMPTY:
  - If set_XID=0, set_YID=0 and cand is non-zero, let w be the lowest set index of cand.
  - PE_opsum_ready[w]=1 combinationally, all other ready bits 0.
  - At the clock edge: PE_data_out <= PE_opsum_data[w], GLB_opsum_valid <= 1, state -> FULL.
  - If popcount(match & PE_opsum_valid) > 1, set multi_match_err. It clears only on reset.
  - If a scan enable is high or cand is zero, all ready bits are 0 and the state stays EMPTY.
- FULL:
  - All PE_opsum_ready bits are 0.
  - PE_data_out is stable.
  - If GLB_opsum_ready=1: GLB_opsum_valid <= 0 and state -> EMPTY.
- No pass-through: the block never accepts from a PE in the same cycle it drains to the controller.
  - The controller advances its tags on the handshake edge, so a same-cycle accept would use stale tags.
  - Minimum spacing is therefore 2 cycles per word, plus the controller's ready latency.
- Latency: a PE handshake in cycle n makes GLB_opsum_valid=1 in cycle n+1.
- Handshake rules: GLB_opsum_valid never drops without GLB_opsum_ready; data is held until the handshake.
- Tag changes while FULL have no effect on the held word.
- A PE_opsum_valid deasserting in EMPTY before a handshake drops nothing, since nothing was accepted.
- Scan during FULL: the held word is unaffected; new IDs take effect from the next EMPTY cycle.

Decomposition:
- Shared package (pe_array_pkg): NUMS_PE_ROW, NUMS_PE_COL, XID_BITS, YID_BITS, DATA_BITS constants; collector state enum (EMPTY, FULL).
- Sub-module: id_match_arbiter.
  - Combinational: ID tables plus tags plus valids in; one-hot grant, any-grant and multi-match flag out.
  - The top level holds the scan tables, FSM and output register.

Test Plan:
1. Scan load: 48 cycles of set_XID with XID[k]=k%8 and 6 cycles of set_YID with YID[r]=r; then tag (3,2) with all PEs valid -> only PE_opsum_ready[19] pulses, and the next cycle GLB_opsum_valid=1 with PE_data_out = PE 19's data.
2. Backpressure: hold GLB_opsum_ready=0 for 10 cycles after FULL -> valid stays 1, data stays constant, no PE ready. Raise ready for 1 cycle -> valid=0 the next cycle.
3. Multi-match: XID=0 for all PEs, YID=0 for all rows, tag (0,0), PEs 5 and 12 valid -> ready[5] only, PE_data_out = PE 5's data, multi_match_err=1 and stays 1.
4. Gating: tag matches PE 7 with PE_en[7]=0 -> no ready pulse and GLB_opsum_valid stays 0. Assert set_XID during a valid match -> no accept.
5. Stream: 8 words with the controller toggling ready and advancing the tag each handshake -> 8 distinct correct words, at most one accept per EMPTY period, minimum 2-cycle spacing.
6. Reset in FULL: pulse rst=0 mid-hold -> valid=0, data=0, err=0 immediately; after reset, tag (0,0) with all PEs valid -> ready[0] pulses.
